// File: rtl/dout_cap_pkg.sv
// Shared types and constants for the CPU data-output capture FIFO.
// The entry layout gains a timestamp field when DOUT_TIMESTAMP_EN is defined.
package dout_cap_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int TS_W_DEF   = 16;

`ifdef DOUT_TIMESTAMP_EN
   typedef struct packed {
      logic [TS_W_DEF-1:0]   ts;
      logic [DATA_W_DEF-1:0] data;
   } entry_t;
`else
   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
   } entry_t;
`endif

   typedef enum logic {
      EMPTY_ST  = 1'b0,
      ACTIVE_ST = 1'b1
   } occ_state_e;

   // Pointer width for a power-of-two depth; never narrower than one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage : dout_cap_pkg

// File: rtl/dcap_fifo_core.sv
// Generic first-word-fall-through FIFO with occupancy count and full/empty flags.
// A pop on a full FIFO frees the slot that a same-cycle push then fills.
module dcap_fifo_core
   import dout_cap_pkg::*;
#(
   parameter int  DEPTH  = 8,
   parameter type item_t = entry_t,
   localparam int PW     = ptr_w(DEPTH),
   localparam int CW     = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  item_t         wr_item_i,
   input  logic          pop_i,
   output item_t         rd_item_o,
   output logic          rd_valid_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   item_t         mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   occ_state_e    state_q, state_d;
   logic          do_push, do_pop;

   assign empty_o    = (state_q == EMPTY_ST);
   assign full_o     = (count_q == DEPTH_C);
   assign rd_valid_o = !empty_o;
   assign count_o    = count_q;
   // Head word is forced to zero while empty so reset presents a clean bus.
   assign rd_item_o  = empty_o ? item_t'('0) : mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      state_d = (count_d == '0) ? EMPTY_ST : ACTIVE_ST;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= EMPTY_ST;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_item_i;
      end
   end

endmodule : dcap_fifo_core

// File: rtl/dout_capture_fifo.sv
// Captures each change of the CPU output bus into an FWFT FIFO with a saturating drop counter.
// Define DOUT_TIMESTAMP_EN to tag every entry with a free-running cycle count (rd_ts port).
module dout_capture_fifo
   import dout_cap_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 8,
   parameter int OVF_W  = 8,
   parameter int TS_W   = TS_W_DEF
) (
   input  logic                   clk,
   input  logic                   sys_rst,
   input  logic [DATA_W-1:0]      dout_in,
   input  logic                   cap_en,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
`ifdef DOUT_TIMESTAMP_EN
   output logic [TS_W-1:0]        rd_ts,
`endif
   output logic [OVF_W-1:0]       ovf_cnt
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || OVF_W < 1 || TS_W < 1) begin : g_bad_cfg
      $error("dout_capture_fifo: DEPTH must be a power of two >= 2");
   end

`ifdef DOUT_TIMESTAMP_EN
   typedef struct packed {
      logic [TS_W-1:0]   ts;
      logic [DATA_W-1:0] data;
   } cap_item_t;
`else
   typedef struct packed {
      logic [DATA_W-1:0] data;
   } cap_item_t;
`endif

   logic [DATA_W-1:0] prev_q;
   logic [OVF_W-1:0]  ovf_q, ovf_d;
   logic              push_req, pop, drop;
   cap_item_t         wr_item, rd_item;

   assign push_req = cap_en && (dout_in != prev_q);
   assign pop      = rd_valid && rd_ready;
   assign drop     = push_req && full && !pop;

   assign rd_data  = rd_item.data;
   assign ovf_cnt  = ovf_q;

`ifdef DOUT_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
      end
   end

   assign rd_ts = rd_item.ts;
`endif

   always_comb begin
      wr_item      = '0;
      wr_item.data = dout_in;
`ifdef DOUT_TIMESTAMP_EN
      wr_item.ts   = ts_q;
`endif
   end

   always_comb begin
      ovf_d = ovf_q;
      if (drop && (ovf_q != '1)) begin
         ovf_d = ovf_q + OVF_W'(1);
      end
   end

   // prev_q follows the bus even while gated, so a change made with cap_en=0 is never replayed.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         prev_q <= '0;
         ovf_q  <= '0;
      end else begin
         prev_q <= dout_in;
         ovf_q  <= ovf_d;
      end
   end

   dcap_fifo_core #(
      .DEPTH  (DEPTH),
      .item_t (cap_item_t)
   ) u_core (
      .clk        (clk),
      .rst        (sys_rst),
      .push_i     (push_req),
      .wr_item_i  (wr_item),
      .pop_i      (pop),
      .rd_item_o  (rd_item),
      .rd_valid_o (rd_valid),
      .full_o     (full),
      .empty_o    (empty),
      .count_o    (count)
   );

endmodule : dout_capture_fifo

// File: tb/tb_dout_capture_fifo.sv
// Directed self-checking bench for dout_capture_fifo (default depth 8, 8-bit overflow counter).
// The timestamp scenario is compiled in only when DOUT_TIMESTAMP_EN is defined.
module tb_dout_capture_fifo;

   logic        clk = 1'b0;
   logic        sys_rst;
   logic [15:0] dout_in;
   logic        cap_en;
   logic        rd_ready;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        full;
   logic        empty;
   logic [3:0]  count;
   logic [7:0]  ovf_cnt;
`ifdef DOUT_TIMESTAMP_EN
   logic [15:0] rd_ts;
`endif

   int checks   = 0;
   int failures = 0;

   dout_capture_fifo dut (
      .clk      (clk),
      .sys_rst  (sys_rst),
      .dout_in  (dout_in),
      .cap_en   (cap_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .full     (full),
      .empty    (empty),
      .count    (count),
`ifdef DOUT_TIMESTAMP_EN
      .rd_ts    (rd_ts),
`endif
      .ovf_cnt  (ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drive one cycle of inputs at the falling edge, then advance past the next rising edge.
   task automatic applyStimulus(input logic [15:0] d, input logic c, input logic r);
      dout_in  = d;
      cap_en   = c;
      rd_ready = r;
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   initial begin
      logic [15:0] expv;

      sys_rst  = 1'b1;
      dout_in  = 16'h0000;
      cap_en   = 1'b0;
      rd_ready = 1'b0;
      #1;
      checkOutput("rst_valid", 32'(rd_valid), 32'd0);
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_ovf", 32'(ovf_cnt), 32'd0);
      checkOutput("rst_data", 32'(rd_data), 32'd0);
      tick();
      tick();
      sys_rst = 1'b0;

      // Idle: zero bus right after reset is never a change.
      for (int i = 0; i < 20; i++) applyStimulus(16'h0000, 1'b1, 1'b0);
      checkOutput("idle_valid", 32'(rd_valid), 32'd0);
      checkOutput("idle_empty", 32'(empty), 32'd1);
      checkOutput("idle_count", 32'(count), 32'd0);
      checkOutput("idle_ovf", 32'(ovf_cnt), 32'd0);

      // Single capture visible one edge after the change is sampled.
      applyStimulus(16'h0001, 1'b1, 1'b0);
      checkOutput("single_valid", 32'(rd_valid), 32'd1);
      checkOutput("single_data", 32'(rd_data), 32'h0001);
      checkOutput("single_count", 32'(count), 32'd1);
      applyStimulus(16'h0001, 1'b1, 1'b1);
      checkOutput("single_pop_empty", 32'(empty), 32'd1);
      checkOutput("single_pop_count", 32'(count), 32'd0);

      // Overflow: ten changes into eight slots drop the last two.
      applyStimulus(16'h0000, 1'b0, 1'b0);
      for (int v = 1; v <= 10; v++) applyStimulus(16'(v), 1'b1, 1'b0);
      checkOutput("ovf_full", 32'(full), 32'd1);
      checkOutput("ovf_count", 32'(count), 32'd8);
      checkOutput("ovf_cnt", 32'(ovf_cnt), 32'd2);
      for (int v = 1; v <= 8; v++) begin
         checkOutput("ovf_drain_data", 32'(rd_data), 32'(v));
         applyStimulus(16'h000A, 1'b1, 1'b1);
      end
      checkOutput("ovf_drain_empty", 32'(empty), 32'd1);
      checkOutput("ovf_drain_ovf", 32'(ovf_cnt), 32'd2);

      // Full FIFO with simultaneous push and pop accepts the push.
      for (int v = 16'h11; v <= 16'h18; v++) applyStimulus(16'(v), 1'b1, 1'b0);
      checkOutput("fpp_pre_full", 32'(full), 32'd1);
      applyStimulus(16'h00FF, 1'b1, 1'b1);
      checkOutput("fpp_count", 32'(count), 32'd8);
      checkOutput("fpp_full", 32'(full), 32'd1);
      checkOutput("fpp_ovf", 32'(ovf_cnt), 32'd2);
      for (int i = 0; i < 8; i++) begin
         expv = (i < 7) ? 16'(16'h12 + i) : 16'h00FF;
         checkOutput("fpp_drain_data", 32'(rd_data), 32'(expv));
         applyStimulus(16'h00FF, 1'b1, 1'b1);
      end
      checkOutput("fpp_drain_empty", 32'(empty), 32'd1);

      // Gating: changes under cap_en=0 are not captured, nor replayed once enabled.
      applyStimulus(16'h1234, 1'b0, 1'b0);
      applyStimulus(16'h5678, 1'b0, 1'b0);
      applyStimulus(16'h5678, 1'b1, 1'b0);
      checkOutput("gate_count", 32'(count), 32'd0);
      checkOutput("gate_empty", 32'(empty), 32'd1);

      // Asynchronous reset between edges with five entries buffered.
      for (int v = 16'h21; v <= 16'h25; v++) applyStimulus(16'(v), 1'b1, 1'b0);
      checkOutput("mid_pre_count", 32'(count), 32'd5);
      #2 sys_rst = 1'b1;
      dout_in = 16'h0000;
      #1;
      checkOutput("mid_rst_count", 32'(count), 32'd0);
      checkOutput("mid_rst_valid", 32'(rd_valid), 32'd0);
      checkOutput("mid_rst_ovf", 32'(ovf_cnt), 32'd0);
      checkOutput("mid_rst_empty", 32'(empty), 32'd1);
      #1 sys_rst = 1'b0;
      tick();
      applyStimulus(16'h0000, 1'b1, 1'b0);
      checkOutput("post_rst_count", 32'(count), 32'd0);

      // Overflow counter saturates at all-ones.
      for (int v = 16'h31; v <= 16'h38; v++) applyStimulus(16'(v), 1'b1, 1'b0);
      for (int i = 0; i < 260; i++) applyStimulus(i[0] ? 16'h00A1 : 16'h00A0, 1'b1, 1'b0);
      checkOutput("sat_ovf", 32'(ovf_cnt), 32'd255);
      checkOutput("sat_count", 32'(count), 32'd8);
      checkOutput("sat_head", 32'(rd_data), 32'h0031);

`ifdef DOUT_TIMESTAMP_EN
      // Changes placed in cycles 4 and 9 after reset release carry those counter values.
      sys_rst  = 1'b1;
      dout_in  = 16'h0000;
      cap_en   = 1'b1;
      rd_ready = 1'b0;
      tick();
      tick();
      sys_rst = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 1'b1, 1'b0);
      applyStimulus(16'h0044, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(16'h0044, 1'b1, 1'b0);
      applyStimulus(16'h0099, 1'b1, 1'b0);
      checkOutput("ts_count", 32'(count), 32'd2);
      checkOutput("ts_first", 32'(rd_ts), 32'd4);
      checkOutput("ts_first_data", 32'(rd_data), 32'h0044);
      applyStimulus(16'h0099, 1'b1, 1'b1);
      checkOutput("ts_second", 32'(rd_ts), 32'd9);
      checkOutput("ts_second_data", 32'(rd_data), 32'h0099);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dout_capture_fifo
